// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: shared types and constants for the two-source interrupt
// controller.
//   state_t          - controller FSM states (IDLE / REQ / SERVICE)
//   SRC_ONE/SRC_TWO  - bit index of each source in pending/in_service
//   ID_*             - one-hot source ids presented on irq_id
//   DEF_VEC_*        - default handler addresses
//   eret_clear()     - drops the highest-priority in-service bit
package int_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam int SRC_ONE = 0;
    localparam int SRC_TWO = 1;

    localparam logic [1:0] ID_NONE = 2'b00;
    localparam logic [1:0] ID_ONE  = 2'b01;
    localparam logic [1:0] ID_TWO  = 2'b10;

    localparam logic [31:0] DEF_VEC_ONE = 32'h0000_0100;
    localparam logic [31:0] DEF_VEC_TWO = 32'h0000_0200;

    // Return from a handler always retires the most urgent active level:
    // source one if it is in service, otherwise source two.
    function automatic logic [1:0] eret_clear(input logic [1:0] isv);
        logic [1:0] w_res;
        w_res = isv;
        if (isv[SRC_ONE]) begin
            w_res[SRC_ONE] = 1'b0;
        end else begin
            w_res[SRC_TWO] = 1'b0;
        end
        return w_res;
    endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// int_ctrl_if: CPU-facing request/ack bus of the interrupt controller.
//   irq_en, irq_ack, irq_eret        : CPU -> controller
//   irq_req, irq_vector, irq_id      : controller -> CPU request
//   pending, in_service, irq_overrun : controller status
// Modports: master = controller side, slave = CPU side.
interface int_ctrl_if;
    logic        irq_en;
    logic        irq_ack;
    logic        irq_eret;
    logic        irq_req;
    logic [31:0] irq_vector;
    logic [1:0]  irq_id;
    logic [1:0]  pending;
    logic [1:0]  in_service;
    logic        irq_overrun;

    modport master (
        input  irq_en, irq_ack, irq_eret,
        output irq_req, irq_vector, irq_id, pending, in_service, irq_overrun
    );

    modport slave (
        output irq_en, irq_ack, irq_eret,
        input  irq_req, irq_vector, irq_id, pending, in_service, irq_overrun
    );
endinterface

// File: rtl/int_edge_sync.sv
// int_edge_sync: two-flop synchronizer for an asynchronous interrupt level
// plus a third flop for rising-edge detection. A level held high yields a
// single-cycle o_rise pulse.
//   clk, rst : clock, asynchronous active-high reset
//   i_async  : raw asynchronous level
//   o_rise   : one-cycle pulse, high the cycle after the level reaches r_sync2
module int_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise
);
    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_rise = r_sync2 & ~r_prev;
endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: two-source priority interrupt controller (source one highest).
// Synchronizes interrupt_one/interrupt_two, latches rising edges as pending
// requests, presents one request with its handler vector over a req/ack
// handshake and tracks in-service levels until the CPU returns (eret).
//   clk, rst        : clock, asynchronous active-high reset
//   interrupt_one   : async level, highest priority
//   interrupt_two   : async level
//   bus (master)    : irq_en/irq_ack/irq_eret in; irq_req, irq_vector,
//                     irq_id, pending, in_service, irq_overrun out
// Build option: define INT_NEST_EN to let source one preempt while only
// source two is in service (nesting depth 2).
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter logic [31:0] VEC_ONE = DEF_VEC_ONE,
    parameter logic [31:0] VEC_TWO = DEF_VEC_TWO
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       interrupt_one,
    input  logic       interrupt_two,
    int_ctrl_if.master bus
);
    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_pending;
    logic [1:0] r_in_service;
    logic [1:0] r_id;
    logic       r_overrun;
    logic [1:0] w_rise;
    logic [1:0] w_isv_eret;
    logic [1:0] w_take_id;
    logic [1:0] w_ack_id;
    logic       w_latch;
    logic       w_ack;

    int_edge_sync u_sync_one (
        .clk    (clk),
        .rst    (rst),
        .i_async(interrupt_one),
        .o_rise (w_rise[SRC_ONE])
    );

    int_edge_sync u_sync_two (
        .clk    (clk),
        .rst    (rst),
        .i_async(interrupt_two),
        .o_rise (w_rise[SRC_TWO])
    );

    // eret is harmless when nothing is in service: clearing an empty set
    // leaves it empty.
    assign w_isv_eret = bus.irq_eret ? eret_clear(r_in_service) : r_in_service;
    assign w_ack_id   = w_ack ? r_id : ID_NONE;

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_take_id   = ID_NONE;
        w_ack       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.irq_en && (r_pending != 2'b00)) begin
                    w_state_nxt = ST_REQ;
                    w_latch     = 1'b1;
                    w_take_id   = r_pending[SRC_ONE] ? ID_ONE : ID_TWO;
                end
            end
            ST_REQ: begin
                if (bus.irq_ack) begin
                    w_ack       = 1'b1;
                    w_state_nxt = ST_SERVICE;
                end else if (!bus.irq_en) begin
                    // Withdraw: fall back to whatever was running before.
                    w_state_nxt = (w_isv_eret != 2'b00) ? ST_SERVICE : ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (w_isv_eret == 2'b00) begin
                    w_state_nxt = ST_IDLE;
                end
`ifdef INT_NEST_EN
                else if (bus.irq_en && r_pending[SRC_ONE] && (w_isv_eret == ID_TWO)) begin
                    w_state_nxt = ST_REQ;
                    w_latch     = 1'b1;
                    w_take_id   = ID_ONE;
                end
`endif
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_pending    <= 2'b00;
            r_in_service <= 2'b00;
            r_id         <= ID_NONE;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            // A new edge wins over the ack clearing the same source.
            r_pending    <= (r_pending & ~w_ack_id) | w_rise;
            r_in_service <= w_isv_eret | w_ack_id;
            if (w_latch) begin
                r_id <= w_take_id;
            end
            if ((w_rise & r_pending) != 2'b00) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign bus.irq_req     = (r_state == ST_REQ);
    assign bus.irq_id      = bus.irq_req ? r_id : ID_NONE;
    assign bus.irq_vector  = !bus.irq_req ? 32'h0 :
                             (r_id == ID_ONE) ? VEC_ONE : VEC_TWO;
    assign bus.pending     = r_pending;
    assign bus.in_service  = r_in_service;
    assign bus.irq_overrun = r_overrun;
endmodule

// File: tb/tb_int_ctrl.sv
// Testbench for int_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_int_ctrl;
    logic clk;
    logic rst;
    logic interrupt_one;
    logic interrupt_two;

    int_ctrl_if bus ();

    int_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .interrupt_one(interrupt_one),
        .interrupt_two(interrupt_two),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The input seen at edge t-2 (and low at t-3) becomes pending at edge t.
    logic [1:0] h1 = 2'b00, h2 = 2'b00, h3 = 2'b00;
    logic [1:0] m_pend = 2'b00, m_isv = 2'b00, m_id = 2'b00;
    logic       m_req = 1'b0, m_ovr = 1'b0;
    logic [1:0] rise_v, isv_e, clr_v;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                h1 = 0; h2 = 0; h3 = 0;
                m_pend = 0; m_isv = 0; m_id = 0; m_req = 0; m_ovr = 0;
            end else begin
                rise_v = h2 & ~h3;
                h3 = h2;
                h2 = h1;
                h1 = {interrupt_two, interrupt_one};
                isv_e = m_isv;
                if (bus.irq_eret) begin
                    if (m_isv[0]) isv_e[0] = 1'b0;
                    else          isv_e[1] = 1'b0;
                end
                clr_v = 2'b00;
                if (m_req) begin
                    if (bus.irq_ack) begin
                        clr_v = m_id;
                        m_isv = isv_e | m_id;
                        m_req = 1'b0;
                    end else begin
                        m_isv = isv_e;
                        if (!bus.irq_en) m_req = 1'b0;
                    end
                end else if (m_isv == 2'b00) begin
                    if (bus.irq_en && m_pend != 2'b00) begin
                        m_req = 1'b1;
                        m_id  = m_pend[0] ? 2'b01 : 2'b10;
                    end
                end else begin
                    m_isv = isv_e;
`ifdef INT_NEST_EN
                    if (isv_e == 2'b10 && bus.irq_en && m_pend[0]) begin
                        m_req = 1'b1;
                        m_id  = 2'b01;
                    end
`endif
                end
                if ((rise_v & m_pend) != 2'b00) m_ovr = 1'b1;
                m_pend = (m_pend & ~clr_v) | rise_v;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            check("m_req", {31'd0, bus.irq_req}, {31'd0, m_req});
            check("m_id", {30'd0, bus.irq_id}, m_req ? {30'd0, m_id} : 32'd0);
            check("m_vec", bus.irq_vector,
                  !m_req ? 32'd0 : (m_id == 2'b01 ? 32'h100 : 32'h200));
            check("m_pend", {30'd0, bus.pending}, {30'd0, m_pend});
            check("m_isv", {30'd0, bus.in_service}, {30'd0, m_isv});
            check("m_ovr", {31'd0, bus.irq_overrun}, {31'd0, m_ovr});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_src(input logic [1:0] which);
        {interrupt_two, interrupt_one} = which;
        @(negedge clk);
        {interrupt_two, interrupt_one} = 2'b00;
    endtask

    task automatic pulse_ack();
        bus.irq_ack = 1'b1;
        @(negedge clk);
        bus.irq_ack = 1'b0;
    endtask

    task automatic pulse_eret();
        bus.irq_eret = 1'b1;
        @(negedge clk);
        bus.irq_eret = 1'b0;
    endtask

    task automatic wait_req(input string nm);
        int cnt;
        cnt = 0;
        while (!bus.irq_req && cnt < 30) begin
            @(negedge clk);
            cnt++;
        end
        check(nm, {31'd0, bus.irq_req}, 32'd1);
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_req"}, {31'd0, bus.irq_req}, 32'd0);
        check({nm, "_id"}, {30'd0, bus.irq_id}, 32'd0);
        check({nm, "_vec"}, bus.irq_vector, 32'd0);
        check({nm, "_pend"}, {30'd0, bus.pending}, 32'd0);
        check({nm, "_isv"}, {30'd0, bus.in_service}, 32'd0);
        check({nm, "_ovr"}, {31'd0, bus.irq_overrun}, 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cnt;
        logic seen;
        rst = 1'b1;
        interrupt_one = 1'b0;
        interrupt_two = 1'b0;
        bus.irq_en = 1'b0;
        bus.irq_ack = 1'b0;
        bus.irq_eret = 1'b0;
        tick(3);
        check_zero("reset");
        rst = 1'b0;
        tick(2);

        // Single source two, held two cycles: request on the 4th edge.
        bus.irq_en = 1'b1;
        interrupt_two = 1'b1;
        cnt = 0;
        while (!bus.irq_req && cnt < 30) begin
            @(negedge clk);
            cnt++;
            if (cnt == 2) interrupt_two = 1'b0;
        end
        interrupt_two = 1'b0;
        check("lat_two", cnt, 32'd4);
        check("two_id", {30'd0, bus.irq_id}, 32'h2);
        check("two_vec", bus.irq_vector, 32'h200);
        pulse_ack();
        check("two_ack_req", {31'd0, bus.irq_req}, 32'd0);
        check("two_ack_isv", {30'd0, bus.in_service}, 32'h2);
        check("two_ack_pend", {30'd0, bus.pending}, 32'h0);
        pulse_eret();
        check("two_eret_isv", {30'd0, bus.in_service}, 32'h0);
        tick(3);

        // Simultaneous edges: one served first, then two.
        pulse_src(2'b11);
        wait_req("sim_req1");
        check("sim_id1", {30'd0, bus.irq_id}, 32'h1);
        check("sim_vec1", bus.irq_vector, 32'h100);
        check("sim_pend1", {30'd0, bus.pending}, 32'h3);
        pulse_ack();
        check("sim_isv1", {30'd0, bus.in_service}, 32'h1);
        check("sim_pend2", {30'd0, bus.pending}, 32'h2);
        pulse_eret();
        wait_req("sim_req2");
        check("sim_id2", {30'd0, bus.irq_id}, 32'h2);
        check("sim_vec2", bus.irq_vector, 32'h200);
        pulse_ack();
        pulse_eret();
        tick(3);

        // Nesting: two in service, then source one arrives.
        pulse_src(2'b10);
        wait_req("nest_req2");
        pulse_ack();
        check("nest_isv2", {30'd0, bus.in_service}, 32'h2);
        pulse_src(2'b01);
`ifdef INT_NEST_EN
        wait_req("nest_req1");
        check("nest_id1", {30'd0, bus.irq_id}, 32'h1);
        check("nest_vec1", bus.irq_vector, 32'h100);
        pulse_ack();
        check("nest_isv11", {30'd0, bus.in_service}, 32'h3);
        pulse_eret();
        check("nest_isv10", {30'd0, bus.in_service}, 32'h2);
        pulse_eret();
        check("nest_isv00", {30'd0, bus.in_service}, 32'h0);
`else
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.irq_req) seen = 1'b1;
        end
        check("nonest_noreq", {31'd0, seen}, 32'd0);
        check("nonest_pend", {30'd0, bus.pending}, 32'h1);
        pulse_eret();
        wait_req("nonest_req1");
        check("nonest_id1", {30'd0, bus.irq_id}, 32'h1);
        pulse_ack();
        check("nonest_isv", {30'd0, bus.in_service}, 32'h1);
        pulse_eret();
`endif
        tick(3);

        // Overrun with enable low, then withdraw by dropping enable.
        bus.irq_en = 1'b0;
        pulse_src(2'b10);
        tick(2);
        pulse_src(2'b10);
        tick(5);
        check("ovr_flag", {31'd0, bus.irq_overrun}, 32'd1);
        check("ovr_pend", {30'd0, bus.pending}, 32'h2);
        bus.irq_en = 1'b1;
        wait_req("ovr_req");
        bus.irq_en = 1'b0;
        tick(1);
        check("wd_req", {31'd0, bus.irq_req}, 32'd0);
        check("wd_pend", {30'd0, bus.pending}, 32'h2);
        bus.irq_en = 1'b1;
        wait_req("ovr_req2");
        pulse_ack();
        pulse_eret();
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.irq_req) seen = 1'b1;
        end
        check("ovr_once", {31'd0, seen}, 32'd0);

        // Reset in the middle of a request.
        pulse_src(2'b01);
        wait_req("rst_req");
        #2;
        rst = 1'b1;
        #1;
        check_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        tick(2);

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) interrupt_one = ~interrupt_one;
            if ($urandom_range(0, 5) == 0) interrupt_two = ~interrupt_two;
            bus.irq_en   = ($urandom_range(0, 15) != 0);
            bus.irq_ack  = bus.irq_req ? ($urandom_range(0, 1) == 1)
                                       : ($urandom_range(0, 19) == 0);
            bus.irq_eret = (bus.in_service != 2'b00) ? ($urandom_range(0, 4) == 0)
                                                     : ($urandom_range(0, 29) == 0);
            rst          = ($urandom_range(0, 599) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        bus.irq_ack = 1'b0;
        bus.irq_eret = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/int_ctrl.md
# int_ctrl

Two-source priority interrupt controller sitting directly upstream of the pipelined CPU. Synchronizes the asynchronous `interrupt_one` / `interrupt_two` lines, latches rising edges as pending requests and arbitrates them (source one highest). Presents one request plus handler vector to the CPU through a req/ack handshake, and tracks in-service state until the CPU signals return (eret).

## Interface
- `VEC_ONE`, 32'h0000_0100: handler address for source one.
- `VEC_TWO`, 32'h0000_0200: handler address for source two.
- `clk`  in  1: single clock; all state on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `interrupt_one`  in  1: async level, priority one (highest).
- `interrupt_two`  in  1: async level, priority two.
- `irq_en`  in  1: global enable from CPU status register.
- `irq_ack`  in  1: CPU takes the presented interrupt (one-cycle pulse).
- `irq_eret`  in  1: CPU returns from current handler (one-cycle pulse).
- `irq_req`  out  1: request to CPU.
- `irq_vector`  out  32: handler address, valid while `irq_req`=1.
- `irq_id`  out  2: one-hot source of request (01 = one, 10 = two), 00 when idle.
- `pending`  out  2: latched pending bits [0]=one, [1]=two.
- `in_service`  out  2: in-service bits, same encoding.
- `irq_overrun`  out  1: sticky; edge arrived while that source already pending.

## Operation
- Per source: 2-flop synchronizer, third flop for rising-edge detect. A level held high counts once.
- Edge sets `pending[i]`; if `pending[i]` already 1, set `irq_overrun` (sticky until `rst`).
- FSM states IDLE, REQ, SERVICE.
- IDLE: if `irq_en` and any eligible pending -> REQ; latch winner (one beats two) into `irq_id`/`irq_vector`.
- REQ: `irq_req`=1, `irq_id`/`irq_vector` frozen. `irq_ack` -> clear `pending[id]`, set `in_service[id]`, go SERVICE. `irq_en` falling before ack -> withdraw, return to prior state (IDLE or SERVICE), pending kept.
- SERVICE: `irq_eret` clears highest-priority set `in_service` bit; all zero -> IDLE. Eligibility per Configuration; eligible pending with `irq_en` -> REQ.
- `irq_ack` outside REQ, `irq_eret` with `in_service`=00: ignored.
- Same-cycle edge and ack on the same source: pending ends 1 (set wins over clear).
- Same-cycle edges on both sources: both pending; source one requested first.

## Timing
- Reset: all flops 0; `irq_req`=0, `irq_vector`=0, `irq_id`=00, `pending`=00, `in_service`=00, `irq_overrun`=0, state IDLE.
- Input high at edge N -> edge detected after N+1 -> `pending` set after N+2 -> `irq_req` high after N+3 (IDLE, `irq_en`=1).
- Input pulses must span at least one rising `clk` edge; shorter pulses may be lost.
- `irq_ack` at edge M -> `irq_req` low, `in_service` updated after M. Earliest re-request after M+1.
- `irq_eret` at edge E -> `in_service` updated after E.
- `rst` mid-handshake aborts immediately to the reset state; pending requests are discarded.

## Configuration
- `INT_NEST_EN` defined: in SERVICE, pending source one is eligible while only source two is in service (nesting, depth 2). `in_service` may read 11.
- Undefined: nothing is eligible while `in_service`≠00. `in_service` is never 11. Pending requests wait for eret.

## Structure
- Package `int_ctrl_pkg`: FSM state enum, source index constants (`SRC_ONE`=0, `SRC_TWO`=1), one-hot id constants, default vector constants.
- Sub-module `int_edge_sync`: synchronizer plus rising-edge detect, instantiated once per source.

## Test plan
- Reset mid-REQ: `rst` pulse while `irq_req`=1 -> all outputs 0 asynchronously, state IDLE, `pending`=00.
- Single source two: pulse 2 cycles, `irq_en`=1 -> `irq_req` after 4 edges, `irq_vector`=32'h200, `irq_id`=10. Ack -> `in_service`=10. Eret -> 00.
- Simultaneous: both pulse same cycle -> first request `irq_id`=01 / 32'h100. After ack+eret, second request 10 / 32'h200.
- Nesting: two in service, then source one pulse -> with `INT_NEST_EN` request 01, ack gives `in_service`=11, eret -> 10. Without it, no request until eret, then 01.
- Overrun/enable: two pulses on source two before ack -> `irq_overrun`=1, one service only. Drop `irq_en` in REQ -> `irq_req`=0, `pending`=10 retained.
